// File: rtl/rx_drop_stat_pkg.sv
// rx_drop_stat_pkg
// Shared types and helpers for the RX drop-statistics collector.
//   state_t   : snapshot handshake states (IDLE, HOLD)
//   popcount  : counts set bits among the low 'width' bits of a region vector
//   cnt_max   : all-ones value for a counter of the given width
//   sat_add   : saturating add, clamped to cnt_max(width)
//   sat_hit   : 1 when the unclamped sum would exceed cnt_max(width)
package rx_drop_stat_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Region vectors are padded to MAX_REGIONS before popcount, so one function
  // serves every REGIONS value the collector supports.
  localparam int MAX_REGIONS = 8;
  localparam int INC_W_MAX   = $clog2(MAX_REGIONS + 1);

  function automatic logic [INC_W_MAX-1:0] popcount(input logic [MAX_REGIONS-1:0] v,
                                                    input int width);
    logic [INC_W_MAX-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_REGIONS; i++) begin
      if ((i < width) && v[i]) begin
        n = n + INC_W_MAX'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] cnt_max(input int width);
    if (width >= 64) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

  // Operands are zero-extended to 64 bits by the caller; the 65-bit sum can
  // never wrap, so comparing against the width's maximum is exact.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int width);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, cnt_max(width)}) begin
      return cnt_max(width);
    end
    return s[63:0];
  endfunction

  function automatic logic sat_hit(input logic [63:0] a, input logic [63:0] b,
                                   input int width);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s > {1'b0, cnt_max(width)};
  endfunction

endpackage

// File: rtl/rx_drop_stat_cnt.sv
// rx_drop_stat_cnt
// One saturating accumulator with synchronous clear and a sticky saturation flag.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_inc       : increment applied this cycle
//   i_clr       : clear counter and sticky flag (the increment is not kept)
//   o_next      : sat(count + i_inc), the value a snapshot captures this cycle
//   o_sat_next  : sticky flag including any saturation caused by this increment
module rx_drop_stat_cnt
  import rx_drop_stat_pkg::*;
#(
  parameter int CNT_WIDTH = 48,
  parameter int INC_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INC_W-1:0]     i_inc,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_next,
  output logic                 o_sat_next
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sat;
  logic                 w_hit;

  assign o_next     = CNT_WIDTH'(sat_add(64'(r_cnt), 64'(i_inc), CNT_WIDTH));
  assign w_hit      = sat_hit(64'(r_cnt), 64'(i_inc), CNT_WIDTH);
  assign o_sat_next = r_sat | w_hit;

  // On clear the pending increment is dropped here because the snapshot has
  // already taken it through o_next; this keeps accounting exactly-once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= o_next;
      r_sat <= o_sat_next;
    end
  end

endmodule

// File: rtl/rx_drop_stat.sv
// rx_drop_stat
// Drop-statistics collector behind the RX MAC lite buffer drop-event tap.
// Counts frames (EOFs) and dropped frames, exposing them through a
// snapshot/acknowledge handshake. Counters saturate and never lose an event.
//   RX_CLK, RX_RESET_N : clock, asynchronous active-low reset
//   EVT_VLD            : event word valid
//   EVT_EOF, EVT_DROP  : per-region end-of-frame and force-drop flags
//   SNAP_REQ, STAT_ACK : snapshot request (level) and snapshot consumed
//   STAT_VLD           : snapshot registers valid
//   STAT_PKTS/DROPS    : snapshot of frame and drop counts
//   STAT_SAT           : a counter saturated since the last clear
//   PROTO_ERR          : sticky, drop flag seen without EOF in its region
module rx_drop_stat
  import rx_drop_stat_pkg::*;
#(
  parameter int REGIONS       = 4,
  parameter int CNT_WIDTH     = 48,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                 RX_CLK,
  input  logic                 RX_RESET_N,
  input  logic                 EVT_VLD,
  input  logic [REGIONS-1:0]   EVT_EOF,
  input  logic [REGIONS-1:0]   EVT_DROP,
  input  logic                 SNAP_REQ,
  input  logic                 STAT_ACK,
  output logic                 STAT_VLD,
  output logic [CNT_WIDTH-1:0] STAT_PKTS,
  output logic [CNT_WIDTH-1:0] STAT_DROPS,
  output logic                 STAT_SAT,
  output logic                 PROTO_ERR
);

  localparam int INC_W = $clog2(REGIONS + 1);

  logic [INC_W-1:0]     r_incPkts;
  logic [INC_W-1:0]     r_incDrops;
  logic                 r_protoErr;
  state_t               r_state;
  logic                 r_statVld;
  logic [CNT_WIDTH-1:0] r_statPkts;
  logic [CNT_WIDTH-1:0] r_statDrops;
  logic                 r_statSat;

  logic [INC_W-1:0]     w_evtPkts;
  logic [INC_W-1:0]     w_evtDrops;
  logic                 w_snap;
  logic                 w_clr;
  logic [CNT_WIDTH-1:0] w_pktsNext;
  logic [CNT_WIDTH-1:0] w_dropsNext;
  logic                 w_pktsSat;
  logic                 w_dropsSat;

  // A drop bit without its EOF is masked out, so it is never counted.
  assign w_evtPkts  = INC_W'(popcount(MAX_REGIONS'(EVT_EOF), REGIONS));
  assign w_evtDrops = INC_W'(popcount(MAX_REGIONS'(EVT_EOF & EVT_DROP), REGIONS));

  assign w_snap = (r_state == IDLE) && SNAP_REQ;
  assign w_clr  = CLEAR_ON_READ && w_snap;

  // Stage 1: register per-word increments.
  always_ff @(posedge RX_CLK or negedge RX_RESET_N) begin
    if (!RX_RESET_N) begin
      r_incPkts  <= '0;
      r_incDrops <= '0;
    end else if (EVT_VLD) begin
      r_incPkts  <= w_evtPkts;
      r_incDrops <= w_evtDrops;
    end else begin
      r_incPkts  <= '0;
      r_incDrops <= '0;
    end
  end

  always_ff @(posedge RX_CLK or negedge RX_RESET_N) begin
    if (!RX_RESET_N) begin
      r_protoErr <= 1'b0;
    end else if (EVT_VLD && ((EVT_DROP & ~EVT_EOF) != '0)) begin
      r_protoErr <= 1'b1;
    end
  end

  // Stage 2: saturating accumulators.
  rx_drop_stat_cnt #(
    .CNT_WIDTH (CNT_WIDTH),
    .INC_W     (INC_W)
  ) u_pkts (
    .clk        (RX_CLK),
    .rst_n      (RX_RESET_N),
    .i_inc      (r_incPkts),
    .i_clr      (w_clr),
    .o_next     (w_pktsNext),
    .o_sat_next (w_pktsSat)
  );

  rx_drop_stat_cnt #(
    .CNT_WIDTH (CNT_WIDTH),
    .INC_W     (INC_W)
  ) u_drops (
    .clk        (RX_CLK),
    .rst_n      (RX_RESET_N),
    .i_inc      (r_incDrops),
    .i_clr      (w_clr),
    .o_next     (w_dropsNext),
    .o_sat_next (w_dropsSat)
  );

  // Snapshot handshake. The snapshot captures the counter value including
  // this edge's stage-2 increment. In HOLD a request is ignored, so an ACK
  // arriving together with a request only releases the snapshot.
  always_ff @(posedge RX_CLK or negedge RX_RESET_N) begin
    if (!RX_RESET_N) begin
      r_state     <= IDLE;
      r_statVld   <= 1'b0;
      r_statPkts  <= '0;
      r_statDrops <= '0;
      r_statSat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (SNAP_REQ) begin
            r_statPkts  <= w_pktsNext;
            r_statDrops <= w_dropsNext;
            r_statSat   <= w_pktsSat | w_dropsSat;
            r_statVld   <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (STAT_ACK) begin
            r_statVld <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_statVld <= 1'b0;
        end
      endcase
    end
  end

  assign STAT_VLD   = r_statVld;
  assign STAT_PKTS  = r_statPkts;
  assign STAT_DROPS = r_statDrops;
  assign STAT_SAT   = r_statSat;
  assign PROTO_ERR  = r_protoErr;

endmodule

// File: tb/tb_rx_drop_stat.sv
// tb_rx_drop_stat
// Directed bench for rx_drop_stat with REGIONS=4, CNT_WIDTH=16, CLEAR_ON_READ=1.
// All stimulus changes and all output samples happen 1 time unit after a
// rising edge, well away from the active edge.
module tb_rx_drop_stat;

  logic        clk;
  logic        rstN;
  logic        evtVld;
  logic [3:0]  evtEof;
  logic [3:0]  evtDrop;
  logic        snapReq;
  logic        statAck;
  logic        statVld;
  logic [15:0] statPkts;
  logic [15:0] statDrops;
  logic        statSat;
  logic        protoErr;

  int tests = 0;
  int fails = 0;

  rx_drop_stat #(
    .REGIONS       (4),
    .CNT_WIDTH     (16),
    .CLEAR_ON_READ (1'b1)
  ) dut (
    .RX_CLK     (clk),
    .RX_RESET_N (rstN),
    .EVT_VLD    (evtVld),
    .EVT_EOF    (evtEof),
    .EVT_DROP   (evtDrop),
    .SNAP_REQ   (snapReq),
    .STAT_ACK   (statAck),
    .STAT_VLD   (statVld),
    .STAT_PKTS  (statPkts),
    .STAT_DROPS (statDrops),
    .STAT_SAT   (statSat),
    .PROTO_ERR  (protoErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] e, input logic [3:0] d);
    evtVld  = v;
    evtEof  = e;
    evtDrop = d;
  endtask

  // Request a snapshot taken at the next edge.
  task automatic snap_edge();
    snapReq = 1'b1;
    tick();
    snapReq = 1'b0;
  endtask

  task automatic ack_edge();
    statAck = 1'b1;
    tick();
    statAck = 1'b0;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    drive(1'b0, 4'h0, 4'h0);
    snapReq = 1'b0;
    statAck = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  // Everything must come out of reset at zero.
  task automatic test_reset();
    tests++; if (statVld !== 1'b0) begin fails++; $display("[TB] FAIL reset_vld: got %0b expected 0", statVld); end
    tests++; if (statPkts !== 16'd0) begin fails++; $display("[TB] FAIL reset_pkts: got %0d expected 0", statPkts); end
    tests++; if (statDrops !== 16'd0) begin fails++; $display("[TB] FAIL reset_drops: got %0d expected 0", statDrops); end
    tests++; if (statSat !== 1'b0) begin fails++; $display("[TB] FAIL reset_sat: got %0b expected 0", statSat); end
    tests++; if (protoErr !== 1'b0) begin fails++; $display("[TB] FAIL reset_proto: got %0b expected 0", protoErr); end
  endtask

  // Ten full words, half the regions dropped: 40 frames, 20 drops.
  task automatic test_basic();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'hF, 4'h5);
      tick();
    end
    drive(1'b0, 4'h0, 4'h0);
    snapReq = 1'b1;
    tests++; if (statVld !== 1'b0) begin fails++; $display("[TB] FAIL basic_vld_pre: got %0b expected 0", statVld); end
    tick();
    snapReq = 1'b0;
    tests++; if (statVld !== 1'b1) begin fails++; $display("[TB] FAIL basic_vld: got %0b expected 1", statVld); end
    tests++; if (statPkts !== 16'd40) begin fails++; $display("[TB] FAIL basic_pkts: got %0d expected 40", statPkts); end
    tests++; if (statDrops !== 16'd20) begin fails++; $display("[TB] FAIL basic_drops: got %0d expected 20", statDrops); end
    tests++; if (statSat !== 1'b0) begin fails++; $display("[TB] FAIL basic_sat: got %0b expected 0", statSat); end
    ack_edge();
    tests++; if (statVld !== 1'b0) begin fails++; $display("[TB] FAIL basic_ack: got %0b expected 0", statVld); end
  endtask

  // A held snapshot stays frozen while events and stray requests arrive;
  // ACK wins over a simultaneous request, and the next snapshot holds the 5.
  task automatic test_hold();
    drive(1'b1, 4'h3, 4'h1);
    tick();
    tick();
    drive(1'b0, 4'h0, 4'h0);
    snap_edge();
    tests++; if (statPkts !== 16'd4 || statDrops !== 16'd2) begin fails++; $display("[TB] FAIL hold_first: got %0d/%0d expected 4/2", statPkts, statDrops); end
    drive(1'b1, 4'h1, 4'h0);
    snapReq = 1'b1;
    tick();
    snapReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (statPkts !== 16'd4 || statDrops !== 16'd2 || statVld !== 1'b1) begin fails++; $display("[TB] FAIL hold_frozen: got %0d/%0d vld %0b expected 4/2 vld 1", statPkts, statDrops, statVld); end
    end
    drive(1'b0, 4'h0, 4'h0);
    tick();
    statAck = 1'b1;
    snapReq = 1'b1;
    tick();
    statAck = 1'b0;
    snapReq = 1'b0;
    tests++; if (statVld !== 1'b0) begin fails++; $display("[TB] FAIL hold_ack_wins: got %0b expected 0", statVld); end
    snap_edge();
    tests++; if (statVld !== 1'b1) begin fails++; $display("[TB] FAIL hold_resnap_vld: got %0b expected 1", statVld); end
    tests++; if (statPkts !== 16'd5 || statDrops !== 16'd0) begin fails++; $display("[TB] FAIL hold_resnap: got %0d/%0d expected 5/0", statPkts, statDrops); end
    ack_edge();
  endtask

  // Events stream through a snapshot edge; two snapshots must add up exactly.
  task automatic test_stream();
    logic [3:0] e;
    logic [3:0] d;
    int totP;
    int totD;
    int s1P;
    int s1D;
    totP = 0;
    totD = 0;
    s1P = 0;
    s1D = 0;
    for (int i = 0; i < 20; i++) begin
      e = 4'(i * 7 + 3);
      d = e & 4'hA;
      totP += $countones(e);
      totD += $countones(d);
      drive(1'b1, e, d);
      snapReq = (i == 8);
      statAck = (i == 9);
      tick();
      if (i == 8) begin
        s1P = int'(statPkts);
        s1D = int'(statDrops);
      end
    end
    snapReq = 1'b0;
    statAck = 1'b0;
    drive(1'b0, 4'h0, 4'h0);
    tick();
    snap_edge();
    tests++; if (s1P + int'(statPkts) !== totP) begin fails++; $display("[TB] FAIL stream_pkts_sum: got %0d expected %0d", s1P + int'(statPkts), totP); end
    tests++; if (s1D + int'(statDrops) !== totD) begin fails++; $display("[TB] FAIL stream_drops_sum: got %0d expected %0d", s1D + int'(statDrops), totD); end
    ack_edge();
  endtask

  // Drop without EOF in region 1: flag raised, only region 0's drop counted.
  task automatic test_proto();
    tests++; if (protoErr !== 1'b0) begin fails++; $display("[TB] FAIL proto_pre: got %0b expected 0", protoErr); end
    drive(1'b1, 4'h1, 4'h3);
    tick();
    drive(1'b0, 4'h0, 4'h0);
    tests++; if (protoErr !== 1'b1) begin fails++; $display("[TB] FAIL proto_flag: got %0b expected 1", protoErr); end
    snap_edge();
    tests++; if (statPkts !== 16'd1 || statDrops !== 16'd1) begin fails++; $display("[TB] FAIL proto_counts: got %0d/%0d expected 1/1", statPkts, statDrops); end
    ack_edge();
  endtask

  // 65540 EOFs saturate the 16-bit counter; a clearing snapshot resets it.
  task automatic test_saturation();
    for (int i = 0; i < 16385; i++) begin
      drive(1'b1, 4'hF, 4'h0);
      tick();
    end
    drive(1'b0, 4'h0, 4'h0);
    snap_edge();
    tests++; if (statPkts !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_pkts: got %0d expected 65535", statPkts); end
    tests++; if (statSat !== 1'b1) begin fails++; $display("[TB] FAIL sat_flag: got %0b expected 1", statSat); end
    tests++; if (statDrops !== 16'd0) begin fails++; $display("[TB] FAIL sat_drops: got %0d expected 0", statDrops); end
    ack_edge();
    drive(1'b1, 4'h1, 4'h0);
    tick();
    drive(1'b0, 4'h0, 4'h0);
    snap_edge();
    tests++; if (statPkts !== 16'd1) begin fails++; $display("[TB] FAIL sat_after_clear_pkts: got %0d expected 1", statPkts); end
    tests++; if (statSat !== 1'b0) begin fails++; $display("[TB] FAIL sat_after_clear_flag: got %0b expected 0", statSat); end
    ack_edge();
  endtask

  // Reset while holding a snapshot clears outputs at once, FSM back in IDLE.
  task automatic test_reset_mid_hold();
    drive(1'b1, 4'hF, 4'hF);
    tick();
    tick();
    tick();
    drive(1'b0, 4'h0, 4'h0);
    snap_edge();
    tests++; if (statVld !== 1'b1 || statPkts !== 16'd12) begin fails++; $display("[TB] FAIL rst_hold_pre: got vld %0b pkts %0d expected vld 1 pkts 12", statVld, statPkts); end
    rstN = 1'b0;
    #2;
    tests++; if (statVld !== 1'b0) begin fails++; $display("[TB] FAIL rst_hold_vld: got %0b expected 0", statVld); end
    tests++; if (statPkts !== 16'd0 || statDrops !== 16'd0) begin fails++; $display("[TB] FAIL rst_hold_counts: got %0d/%0d expected 0/0", statPkts, statDrops); end
    tests++; if (protoErr !== 1'b0) begin fails++; $display("[TB] FAIL rst_hold_proto: got %0b expected 0", protoErr); end
    tick();
    rstN = 1'b1;
    tick();
    snap_edge();
    tests++; if (statVld !== 1'b1 || statPkts !== 16'd0) begin fails++; $display("[TB] FAIL rst_hold_idle: got vld %0b pkts %0d expected vld 1 pkts 0", statVld, statPkts); end
    ack_edge();
  endtask

  // Scenarios run in order; the protocol error stays sticky until the final
  // reset scenario, which also checks that reset clears it.
  initial begin
    rstN    = 1'b0;
    evtVld  = 1'b0;
    evtEof  = 4'h0;
    evtDrop = 4'h0;
    snapReq = 1'b0;
    statAck = 1'b0;
    do_reset();
    test_reset();
    test_basic();
    test_hold();
    test_stream();
    test_proto();
    test_saturation();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
